// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream mux family.
// Mode encodings and the channel-index width helper used by stream blocks.
package rr_stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Index width for n channels; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, pick lowest, rotate back.
// Grant is one-hot, or zero when nothing requests.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant
);

    logic [2*N_CH-1:0] req2;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   pick;
    logic [2*N_CH-1:0] pick2;

    assign req2  = {req, req};
    assign rot   = N_CH'(req2 >> ptr);
    // Isolate lowest set bit of the rotated request vector.
    assign pick  = rot & (~rot + N_CH'(1));
    assign pick2 = {pick, pick};
    assign grant = N_CH'((pick2 << ptr) >> N_CH);

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin or fixed channel select.
// One registered output stage tags each beat with its source channel.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [CH_W-1:0]       sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;

    logic [N_CH-1:0]  grant_rr;
    logic [N_CH-1:0]  grant_fx;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic [WIDTH-1:0] data_sel;
    logic             load_en;
    logic             xfer;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (grant_rr)
    );

    // Out-of-range sel never matches a channel, so it yields no grant.
    always_comb begin
        grant_fx = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_fx[i] = in_valid[i] & (sel == CH_W'(i));
        end
    end

    assign grant   = (mode == MODE_FIXED) ? grant_fx : grant_rr;
    assign load_en = ~out_valid_q | out_ready;
    assign xfer    = load_en & (|grant);
    assign in_ready = (load_en & ~rst) ? grant : '0;

    always_comb begin
        grant_idx = '0;
        data_sel  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | CH_W'(i);
            end
            data_sel = data_sel
                     | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = data_sel;
            out_ch_d   = grant_idx;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == CH_W'(N_CH - 1))
                      ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed table, random vs model,
// and hand sequences for reset and a three-channel instance.
module tb_rr_stream_mux;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  r3;
    logic        m3;
    logic [1:0]  s3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ordy3;

    int checks;
    int failures;

    rr_stream_mux #(.N_CH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    rr_stream_mux #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v3),
        .in_data   (d3),
        .in_ready  (r3),
        .mode      (m3),
        .sel       (s3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_ch    (oc3),
        .out_ready (ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic       md;
        logic [1:0] sl;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] och;
        logic [7:0] od;
    } vec_t;

    vec_t tbl [21];

    // Reference model state
    int         m_ptr;
    logic       m_v;
    logic [7:0] m_d;
    int         m_c;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int mgrant(input logic [3:0] v, input logic md,
                                  input logic [1:0] s, input int p);
        if (md) return v[s] ? int'(s) : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int   g;
        logic ld;
        logic [3:0] er;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 4'hF;
        mode = 1'b0;
        sel = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        v3 = '0;
        d3 = '0;
        m3 = 1'b0;
        s3 = 2'd0;
        ordy3 = 1'b1;

        tbl[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2};
        tbl[4]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2};
        tbl[5]  = '{4'hF, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2};
        tbl[6]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
        tbl[7]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[8]  = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[9]  = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[10] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
        tbl[11] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[12] = '{4'h1, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[13] = '{4'h9, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
        tbl[14] = '{4'h9, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[15] = '{4'h0, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 8'hA0};
        tbl[16] = '{4'h4, 1'b0, 2'd0, 1'b0, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[17] = '{4'h4, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 8'hA2};
        tbl[18] = '{4'h4, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA2};
        tbl[19] = '{4'h4, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[20] = '{4'h4, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};

        // Reset held with all channels valid
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid  = tbl[i].vld;
            mode      = tbl[i].md;
            sel       = tbl[i].sl;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d_ch", i), 32'(out_ch), 32'(tbl[i].och));
            chk($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].od));
        end

        // Fresh start for randomized comparison against the model
        rst = 1'b1;
        #2 rst = 1'b0;
        m_ptr = 0;
        m_v = 1'b0;
        m_d = 8'h00;
        m_c = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            mode      = ($urandom_range(0, 3) == 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g  = mgrant(in_valid, mode, sel, m_ptr);
            ld = !m_v || out_ready;
            er = '0;
            if (ld && g >= 0) er[g] = 1'b1;
            chk("rnd_ready", 32'(in_ready), 32'(er));
            if (ld) begin
                if (g >= 0) begin
                    m_v = 1'b1;
                    m_d = in_data[g*8 +: 8];
                    m_c = g;
                    if (!mode) m_ptr = (g + 1) % 4;
                end else begin
                    m_v = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_valid", 32'(out_valid), 32'(m_v));
            chk("rnd_ch", 32'(out_ch), 32'(m_c));
            chk("rnd_data", 32'(out_data), 32'(m_d));
        end

        // Mid-stream asynchronous reset
        in_valid  = 4'hF;
        mode      = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_valid_before", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid_async", 32'(out_valid), 32'd0);
        chk("mid_ready_in_rst", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;

        // Three-channel instance: round-robin wrap and out-of-range sel
        in_valid = 4'h0;
        v3 = 3'b111;
        for (int i = 0; i < 3; i++) d3[i*8 +: 8] = 8'hB0 + 8'(i);
        m3 = 1'b0;
        ordy3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n3_ch%0d", k), 32'(oc3), 32'(k % 3));
            chk($sformatf("n3_data%0d", k), 32'(od3), 32'(8'hB0 + 8'(k % 3)));
        end
        m3 = 1'b1;
        s3 = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(r3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_sel3_valid", 32'(ov3), 32'd0);
        chk("n3_sel3_hold_ch", 32'(oc3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
